// File: rtl/cordic_dds_iq.sv
// Phase-accumulator DDS feeding an iterative rotation-mode CORDIC; emits signed I/Q every ITER+2 cycles.
// No backpressure: start/stop pulses control generation, each sample is flagged by a one-cycle out_valid.
module cordic_dds_iq #(
  parameter int WIDTH  = 12,
  parameter int FREQ_W = 16,
  parameter int ITER   = 12,
  parameter int GUARD  = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic [FREQ_W-1:0] freq,
  input  logic [FREQ_W-1:0] phase_off,
  output logic              busy,
  output logic              out_valid,
  output logic [WIDTH-1:0]  sin_out,
  output logic [WIDTH-1:0]  cos_out
);

  localparam int XW = WIDTH + GUARD + 1;
  localparam int RW = XW + 1;
  localparam int ZW = 18;

  localparam longint AMP  = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint X0_U = (AMP * 6072529 + 5000000) / 10000000;
  localparam logic signed [XW-1:0] X0      = XW'(X0_U << GUARD);
  localparam logic signed [RW-1:0] RND     = RW'((longint'(1) << GUARD) >> 1);
  localparam logic signed [RW-1:0] SAT_MAX = RW'(AMP);
  localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ROT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]              state;
  logic [FREQ_W-1:0]       acc;
  logic                    stop_pend;
  logic                    fold_q;
  logic [4:0]              cnt;
  logic signed [XW-1:0]    x, y;
  logic signed [ZW-1:0]    z;

  logic [FREQ_W-1:0]       ph_sum;
  logic [15:0]             p;
  logic                    fold;
  logic [15:0]             z0_16;
  logic signed [ZW-1:0]    z0;
  logic signed [XW-1:0]    xs, ys;
  logic signed [RW-1:0]    xe, ye, xn, yn, xsh, ysh;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 18'sd8192;
      5'd1:    atan_lut = 18'sd4836;
      5'd2:    atan_lut = 18'sd2555;
      5'd3:    atan_lut = 18'sd1297;
      5'd4:    atan_lut = 18'sd651;
      5'd5:    atan_lut = 18'sd326;
      5'd6:    atan_lut = 18'sd163;
      5'd7:    atan_lut = 18'sd81;
      5'd8:    atan_lut = 18'sd41;
      5'd9:    atan_lut = 18'sd20;
      5'd10:   atan_lut = 18'sd10;
      5'd11:   atan_lut = 18'sd5;
      5'd12:   atan_lut = 18'sd3;
      5'd13:   atan_lut = 18'sd1;
      5'd14:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [RW-1:0] v);
    logic signed [RW-1:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    sat = c[WIDTH-1:0];
  endfunction

  // Quadrants 2/3 rotate by p-pi instead and negate the result, keeping |z0| <= pi/2.
  assign ph_sum = acc + phase_off;
  assign p      = ph_sum[FREQ_W-1 -: 16];
  assign fold   = p[15] ^ p[14];
  assign z0_16  = fold ? (p ^ 16'h8000) : p;
  assign z0     = {{(ZW-16){z0_16[15]}}, z0_16};

  assign xs = x >>> cnt;
  assign ys = y >>> cnt;

  assign xe  = $signed({x[XW-1], x});
  assign ye  = $signed({y[XW-1], y});
  assign xn  = (fold_q ? -xe : xe) + RND;
  assign yn  = (fold_q ? -ye : ye) + RND;
  assign xsh = xn >>> GUARD;
  assign ysh = yn >>> GUARD;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      acc       <= '0;
      stop_pend <= 1'b0;
      fold_q    <= 1'b0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      sin_out   <= '0;
      cos_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (stop && state != S_IDLE)
        stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc    <= acc + freq;
          x      <= X0;
          y      <= '0;
          z      <= z0;
          fold_q <= fold;
          cnt    <= '0;
          state  <= S_ROT;
        end
        S_ROT: begin
          if (!z[ZW-1]) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan_lut(cnt);
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan_lut(cnt);
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1))
            state <= S_DONE;
        end
        default: begin
          sin_out   <= sat(ysh);
          cos_out   <= sat(xsh);
          out_valid <= 1'b1;
          if (stop_pend || stop) begin
            stop_pend <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_LOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_dds_iq.sv
// Directed bench for cordic_dds_iq: float-model scoreboard of expected I/Q samples checked at each strobe.
module tb_cordic_dds_iq;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        stop;
  logic [15:0] freq;
  logic [15:0] phase_off;
  logic        busy;
  logic        out_valid;
  logic [11:0] sin_out;
  logic [11:0] cos_out;

  typedef struct {
    int s;
    int c;
  } samp_t;

  samp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  cordic_dds_iq #(.WIDTH(12), .FREQ_W(16), .ITER(12), .GUARD(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .freq      (freq),
    .phase_off (phase_off),
    .busy      (busy),
    .out_valid (out_valid),
    .sin_out   (sin_out),
    .cos_out   (cos_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic void push_exp(input int p);
    samp_t e;
    real   a;
    a   = 6.283185307179586 * real'(p) / 65536.0;
    e.s = rnd(2047.0 * $sin(a));
    e.c = rnd(2047.0 * $cos(a));
    exp_q.push_back(e);
  endfunction

  task automatic chk_bit(input string tag, input logic got, input logic exp_v);
    n_cmp++;
    assert (got === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp_v, input int tol);
    n_cmp++;
    assert (((got >= exp_v - tol) && (got <= exp_v + tol)) === 1'b1)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, got, exp_v, tol);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 60);
  endtask

  task automatic chk_sample(input string tag);
    samp_t e;
    n_cmp++;
    assert ((exp_q.size() > 0) === 1'b1)
    else begin
      n_bad++;
      $error("FAIL %s_queue: observed empty scoreboard expected a pending sample", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_int({tag, "_sin"}, int'($signed(sin_out)), e.s, 4);
      chk_int({tag, "_cos"}, int'($signed(cos_out)), e.c, 4);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Runs n samples from phase 0, optionally pokes start mid-sample, stops during the last one.
  task automatic run(input string tag, input int f, input int po, input int n, input bit poke);
    int cyc;
    int used;
    freq      = 16'(f);
    phase_off = 16'(po);
    for (int k = 0; k < n; k++)
      push_exp((k * f + po) % 65536);
    pulse_start();
    for (int k = 0; k < n; k++) begin
      used = 0;
      if (k == n - 1) begin
        repeat (3) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        used = 4;
      end else if (poke && k == 2) begin
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        used = 3;
      end
      wait_valid(cyc);
      chk_int({tag, "_period"}, cyc, 14 - used, 0);
      chk_sample(tag);
    end
    chk_bit({tag, "_busy_after_stop"}, busy, 1'b0);
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) cyc++;
    end
    chk_int({tag, "_no_strobe_after_stop"}, cyc, 0, 0);
    chk_bit({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int    cyc;
    samp_t e;
    resetn    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    freq      = '0;
    phase_off = '0;

    repeat (100) @(negedge clock);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_int("rst_sin", int'($signed(sin_out)), 0, 0);
    chk_int("rst_cos", int'($signed(cos_out)), 0, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    chk_bit("idle_no_start", busy, 1'b0);
    chk_bit("idle_no_valid", out_valid, 1'b0);

    run("phase0", 0, 0, 3, 1'b0);
    run("q90", 0, 16384, 2, 1'b0);
    chk_int("q90_hold_sin", int'($signed(sin_out)), 2047, 4);
    run("q180", 0, 32768, 2, 1'b0);
    chk_int("q180_hold_cos", int'($signed(cos_out)), -2047, 4);
    run("q270", 0, 49152, 2, 1'b0);
    run("sweep4096", 4096, 0, 18, 1'b1);
    run("restart", 4096, 0, 3, 1'b0);
    run("sweep65535", 65535, 0, 6, 1'b0);
    run("offset_sweep", 3000, 12345, 5, 1'b1);

    // Reset in the middle of a sample must clear outputs without a clock edge.
    freq      = 16'd0;
    phase_off = 16'd16384;
    push_exp(16384);
    pulse_start();
    wait_valid(cyc);
    chk_int("mid_first_period", cyc, 14, 0);
    chk_sample("mid_first");
    @(negedge clock);
    chk_bit("valid_one_cycle", out_valid, 1'b0);
    repeat (3) @(negedge clock);
    chk_bit("mid_busy_before_rst", busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk_int("mid_rst_sin", int'($signed(sin_out)), 0, 0);
    chk_int("mid_rst_cos", int'($signed(cos_out)), 0, 0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) cyc++;
    end
    chk_int("post_rst_no_strobe", cyc, 0, 0);
    chk_bit("post_rst_idle", busy, 1'b0);
    chk_int("post_rst_queue", exp_q.size(), 0, 0);
    exp_q.delete();

    run("after_rst", 0, 0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
